// File: rtl/logic_unit_pipe.sv
// Registered bitwise gate unit with pairwise and multi-beat fold modes.
// Latency: 1 cycle from the accepted (last) beat to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; single output register, no skid.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats
);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic [CNT_W-1:0] beats;
  } res_t;

  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = x;
    case (sel)
      OP_NOT:  r = ~x;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XOR:  r = x ^ y;
      OP_XNOR: r = ~(x ^ y);
      OP_PASS: r = x;
      default: r = x;
    endcase
    return r;
  endfunction

  // NOT and PASS are unary: each fold beat replaces the accumulator.
  function automatic logic [WIDTH-1:0] fold_step(input logic [2:0] sel,
                                                 input logic [WIDTH-1:0] acc_v,
                                                 input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (sel == OP_PASS)     r = x;
    else if (sel == OP_NOT) r = ~x;
    else                    r = gate_f(sel, acc_v, x);
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_r, op_nxt;
  logic             accept;
  logic             emit;
  res_t             res;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    op_nxt    = op_r;
    emit      = 1'b0;
    res       = '0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!mode) begin
            emit      = 1'b1;
            res.dat   = gate_f(op, a, b);
            res.beats = CNT_ONE;
          end else begin
            op_nxt  = op;
            acc_nxt = (op == OP_NOT) ? ~a : a;
            cnt_nxt = CNT_ONE;
            if (in_last) begin
              emit      = 1'b1;
              res.dat   = acc_nxt;
              res.beats = cnt_nxt;
            end else begin
              state_nxt = ACCUM;
            end
          end
        end
        ACCUM: begin
          acc_nxt = fold_step(op_r, acc, a);
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
          if (in_last) begin
            emit      = 1'b1;
            res.dat   = acc_nxt;
            res.beats = cnt_nxt;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= OP_NOT;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      op_r  <= op_nxt;
    end
  end

  // A result loading in the same cycle as the sink drains the old one keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      out_beats  <= '0;
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_data   <= res.dat;
      out_zero   <= (res.dat == '0);
      out_parity <= ^res.dat;
      out_beats  <= res.beats;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: vector table, directed corner sequences, random run vs queue model.
module tb_logic_unit_pipe;

  localparam logic [2:0] NOT_ = 3'd0, AND_ = 3'd1, OR_ = 3'd2, NAND_ = 3'd3;
  localparam logic [2:0] NOR_ = 3'd4, XOR_ = 3'd5, XNOR_ = 3'd6, PASS_ = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic       mode = 1'b0;
  logic [7:0] a = 8'd0, b = 8'd0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, out_zero, out_parity;
  logic [7:0] out_data, out_beats;
  logic       in_ready2, out_valid2, out_zero2, out_parity2;
  logic [7:0] out_data2;
  logic [1:0] out_beats2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mode(mode), .a(a), .b(b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_parity(out_parity), .out_beats(out_beats)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .mode(mode), .a(a), .b(b), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_zero(out_zero2), .out_parity(out_parity2), .out_beats(out_beats2)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } pw_vec_t;

  pw_vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gate_ref(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      NOT_:    return ~x;
      AND_:    return x & y;
      OR_:     return x | y;
      NAND_:   return ~(x & y);
      NOR_:    return ~(x | y);
      XOR_:    return x ^ y;
      XNOR_:   return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  // Fold of a whole packet; first beat seeds the result, unary ops keep only the newest beat.
  function automatic logic [7:0] fold_ref(input logic [2:0] o, input logic [7:0] q[$]);
    logic [7:0] r;
    r = (o == NOT_) ? ~q[0] : q[0];
    for (int i = 1; i < q.size(); i++) begin
      if (o == PASS_)     r = q[i];
      else if (o == NOT_) r = ~q[i];
      else                r = gate_ref(o, r, q[i]);
    end
    return r;
  endfunction

  task automatic send_beat(input logic [2:0] o, input logic m, input logic [7:0] av,
                           input logic [7:0] bv, input logic last);
    int guard;
    in_valid = 1'b1; op = o; mode = m; a = av; b = bv; in_last = last;
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("send_beat_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle;
    @(posedge clk); #1;
  endtask

  logic       mv;
  logic [7:0] exp_dat;
  int         exp_n;
  logic [7:0] pkt[$];
  logic [2:0] pkt_op;
  logic       exp_rdy, produced;
  logic [7:0] res_v;
  int         res_n;

  initial begin
    tbl[0] = '{NOT_,  8'hF0, 8'h3C, 8'h0F};
    tbl[1] = '{AND_,  8'hF0, 8'h3C, 8'h30};
    tbl[2] = '{OR_,   8'hF0, 8'h3C, 8'hFC};
    tbl[3] = '{NAND_, 8'hF0, 8'h3C, 8'hCF};
    tbl[4] = '{NOR_,  8'hF0, 8'h3C, 8'h03};
    tbl[5] = '{XOR_,  8'hF0, 8'h3C, 8'hCC};
    tbl[6] = '{XNOR_, 8'hF0, 8'h3C, 8'h33};
    tbl[7] = '{PASS_, 8'hF0, 8'h3C, 8'hF0};

    #2;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_out_beats", 32'(out_beats), 0);
    chk("reset_out_zero", 32'(out_zero), 0);
    chk("reset_out_parity", 32'(out_parity), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Pairwise table, back-to-back, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = tbl[i].op; mode = 1'b0; a = tbl[i].a; b = tbl[i].b; in_last = 1'b0;
      #1 chk("pw_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      chk("pw_out_valid", 32'(out_valid), 1);
      chk("pw_out_data", 32'(out_data), 32'(tbl[i].exp));
      chk("pw_out_beats", 32'(out_beats), 1);
    end
    in_valid = 1'b0;

    // Fold XOR 01,02,04.
    send_beat(XOR_, 1'b1, 8'h01, 8'h00, 1'b0);
    chk("fxor_no_valid1", 32'(out_valid), 0);
    send_beat(XOR_, 1'b1, 8'h02, 8'h00, 1'b0);
    chk("fxor_no_valid2", 32'(out_valid), 0);
    send_beat(XOR_, 1'b1, 8'h04, 8'h00, 1'b1);
    chk("fxor_valid", 32'(out_valid), 1);
    chk("fxor_data", 32'(out_data), 32'h07);
    chk("fxor_parity", 32'(out_parity), 1);
    chk("fxor_beats", 32'(out_beats), 3);
    chk("fxor_zero", 32'(out_zero), 0);

    // Fold AND FF,0F,F0.
    send_beat(AND_, 1'b1, 8'hFF, 8'h00, 1'b0);
    send_beat(AND_, 1'b1, 8'h0F, 8'h00, 1'b0);
    send_beat(AND_, 1'b1, 8'hF0, 8'h00, 1'b1);
    chk("fand_data", 32'(out_data), 0);
    chk("fand_zero", 32'(out_zero), 1);

    // Fold NAND FF,FF.
    send_beat(NAND_, 1'b1, 8'hFF, 8'h00, 1'b0);
    send_beat(NAND_, 1'b1, 8'hFF, 8'h00, 1'b1);
    chk("fnand_data", 32'(out_data), 0);
    chk("fnand_beats", 32'(out_beats), 2);

    // Single-beat fold NOT.
    send_beat(NOT_, 1'b1, 8'h5A, 8'h00, 1'b1);
    chk("fnot_valid", 32'(out_valid), 1);
    chk("fnot_data", 32'(out_data), 32'hA5);
    chk("fnot_beats", 32'(out_beats), 1);
    chk("fnot_parity", 32'(out_parity), 0);

    // Backpressure: hold for 5 cycles, then drain and load in one cycle.
    idle_cycle();
    chk("bp_drained", 32'(out_valid), 0);
    out_ready = 1'b0;
    send_beat(XOR_, 1'b0, 8'hAA, 8'h55, 1'b0);
    in_valid = 1'b1; op = AND_; mode = 1'b0; a = 8'h0F; b = 8'h3C; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready_low", 32'(in_ready), 0);
      chk("bp_valid_held", 32'(out_valid), 1);
      chk("bp_data_held", 32'(out_data), 32'hFF);
      chk("bp_beats_held", 32'(out_beats), 1);
      chk("bp_zero_held", 32'(out_zero), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("bp_in_ready_high", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_new_valid", 32'(out_valid), 1);
    chk("bp_new_data", 32'(out_data), 32'h0C);
    idle_cycle();
    chk("bp_cleared", 32'(out_valid), 0);

    // op/mode changes mid-packet ignored.
    send_beat(OR_, 1'b1, 8'h01, 8'hFF, 1'b0);
    send_beat(AND_, 1'b0, 8'h10, 8'h00, 1'b0);
    send_beat(AND_, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("fopr_data", 32'(out_data), 32'h11);
    chk("fopr_beats", 32'(out_beats), 3);

    // 5-beat fold: narrow counter saturates.
    send_beat(OR_, 1'b1, 8'h01, 8'h00, 1'b0);
    send_beat(AND_, 1'b1, 8'h02, 8'h00, 1'b0);
    send_beat(AND_, 1'b1, 8'h04, 8'h00, 1'b0);
    send_beat(AND_, 1'b1, 8'h08, 8'h00, 1'b0);
    send_beat(AND_, 1'b1, 8'h10, 8'h00, 1'b1);
    chk("sat_data", 32'(out_data2), 32'h1F);
    chk("sat_beats_wide", 32'(out_beats), 5);
    chk("sat_beats_narrow", 32'(out_beats2), 3);

    // Reset in the middle of a fold.
    send_beat(OR_, 1'b0, 8'h7F, 8'h00, 1'b0);
    send_beat(XOR_, 1'b1, 8'h3C, 8'h00, 1'b0);
    send_beat(XOR_, 1'b1, 8'hC3, 8'h00, 1'b0);
    chk("rst_pre_data", 32'(out_data), 32'h7F);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_beats", 32'(out_beats), 0);
    chk("rst_out_parity", 32'(out_parity), 0);
    chk("rst_out_zero", 32'(out_zero), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(AND_, 1'b0, 8'h0F, 8'hFF, 1'b0);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data", 32'(out_data), 32'h0F);
    chk("post_rst_beats", 32'(out_beats), 1);
    idle_cycle();

    // Random traffic against the packet-level model.
    mv = 1'b0; exp_dat = 8'h00; exp_n = 0; pkt.delete(); pkt_op = NOT_;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom);
      mode      = ($urandom_range(0, 2) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      in_last   = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !mv || out_ready;
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rnd_out_valid", 32'(out_valid), 32'(mv));
      if (mv) begin
        chk("rnd_out_data", 32'(out_data), 32'(exp_dat));
        chk("rnd_out_zero", 32'(out_zero), (exp_dat == 8'h00) ? 1 : 0);
        chk("rnd_out_parity", 32'(out_parity), 32'(^exp_dat));
        chk("rnd_out_beats", 32'(out_beats), (exp_n > 255) ? 255 : exp_n);
        chk("rnd_out_beats_sat", 32'(out_beats2), (exp_n > 3) ? 3 : exp_n);
      end
      produced = 1'b0;
      res_v = 8'h00;
      res_n = 0;
      if (in_valid && exp_rdy) begin
        if (pkt.size() == 0 && !mode) begin
          res_v = gate_ref(op, a, b);
          res_n = 1;
          produced = 1'b1;
        end else begin
          if (pkt.size() == 0) pkt_op = op;
          pkt.push_back(a);
          if (in_last) begin
            res_v = fold_ref(pkt_op, pkt);
            res_n = pkt.size();
            pkt.delete();
            produced = 1'b1;
          end
        end
      end
      if (produced) begin
        mv = 1'b1; exp_dat = res_v; exp_n = res_n;
      end else if (out_ready) begin
        mv = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
